// File: rtl/logic_exec_unit.sv
// Purpose: 64-bit bitwise-logic execution unit with a 2-entry result queue toward the CDB.
// Latency: 1 cycle from accept edge to out_valid; results leave strictly in acceptance order.
// Backpressure: in_ready = (cnt < 2) from registered state only; out_ready stalls the queue.
//
// Ports:
//   clk, reset_n (async active-low), flush (synchronous squash of all queued work)
//   in_valid/in_ready, in_op[2:0], in_a, in_b, in_tag  : issue side
//   out_valid/out_ready, out_data, out_tag             : CDB side
//   out_flags[1:0] = {N, Z}                            : only when LOGIC_EXEC_FLAGS_EN is defined
//
// Optional feature macro: LOGIC_EXEC_FLAGS_EN (per-entry N/Z flag storage and out_flags port).
module logic_exec_unit #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef LOGIC_EXEC_FLAGS_EN
  ,
  output logic [1:0]       out_flags
`endif
);

  // Queue storage, indexed by 1-bit read/write pointers.
  logic [WIDTH-1:0] r_data_mem [0:1];
  logic [TAG_W-1:0] r_tag_mem  [0:1];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;

  // Registered copy of the head entry; ports are driven straight from these.
  logic [WIDTH-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;

  logic [WIDTH-1:0] w_result;
  logic             w_accept;
  logic             w_pop;
  logic             w_load_new;
  logic             w_load_next;

  always_comb begin
    w_result = '0;
    case (in_op)
      3'd0:    w_result = in_a & in_b;
      3'd1:    w_result = in_a | in_b;
      3'd2:    w_result = in_a ^ in_b;
      3'd3:    w_result = ~(in_a | in_b);
      3'd4:    w_result = ~(in_a & in_b);
      3'd5:    w_result = ~(in_a ^ in_b);
      3'd6:    w_result = in_a & ~in_b;
      default: w_result = in_a | ~in_b;
    endcase
  end

  assign in_ready  = (r_cnt < 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // The new result becomes the head when the queue is (or is about to be) empty.
  assign w_load_new  = w_accept && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));
  // Popping a full queue promotes the older surviving entry to the head.
  assign w_load_next = w_pop && (r_cnt == 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= 2'd0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_data_mem[0] <= '0;
      r_data_mem[1] <= '0;
      r_tag_mem[0]  <= '0;
      r_tag_mem[1]  <= '0;
    end else if (flush) begin
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data_mem[r_wr_ptr] <= w_result;
        r_tag_mem[r_wr_ptr]  <= in_tag;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, w_accept} - {1'b0, w_pop};
    end
  end

  // Head registers hold their last value when the queue drains or is flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else if (w_load_new) begin
      r_out_data <= w_result;
      r_out_tag  <= in_tag;
    end else if (w_load_next) begin
      r_out_data <= r_data_mem[~r_rd_ptr];
      r_out_tag  <= r_tag_mem[~r_rd_ptr];
    end
  end

  assign out_data = r_out_data;
  assign out_tag  = r_out_tag;

`ifdef LOGIC_EXEC_FLAGS_EN
  logic [1:0] r_flags_mem [0:1];
  logic [1:0] r_out_flags;
  logic [1:0] w_flags;

  assign w_flags = {w_result[WIDTH-1], (w_result == '0)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags_mem[0] <= 2'b00;
      r_flags_mem[1] <= 2'b00;
      r_out_flags    <= 2'b00;
    end else begin
      if (w_accept) begin
        r_flags_mem[r_wr_ptr] <= w_flags;
      end
      if (w_load_new) begin
        r_out_flags <= w_flags;
      end else if (w_load_next) begin
        r_out_flags <= r_flags_mem[~r_rd_ptr];
      end
    end
  end

  assign out_flags = r_out_flags;
`endif

endmodule

// File: tb/tb_logic_exec_unit.sv
// Purpose: self-checking bench for logic_exec_unit against a queue-based reference model.
// Latency: model result visible the cycle after its accept edge, checked every falling edge.
// Backpressure: directed out_ready patterns exercise stall, full queue, flush and async reset.
module tb_logic_exec_unit;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [5:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [5:0]  out_tag;
`ifdef LOGIC_EXEC_FLAGS_EN
  logic [1:0]  out_flags;
`endif

  int total;
  int bad;

  logic_exec_unit #(.WIDTH(64), .TAG_W(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef LOGIC_EXEC_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each op is a 2-input truth table applied bit by bit, index {a,b}.
  function automatic logic [63:0] model_res(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [3:0]  tt;
    logic [63:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0100;
      default: tt = 4'b1101;
    endcase
    for (int i = 0; i < 64; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  typedef struct packed {
    logic [63:0] d;
    logic [5:0]  t;
    logic [1:0]  f;
  } ent_t;

  ent_t exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    bit   acc;
    bit   pp;
    ent_t e;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      acc = in_valid && (exp_q.size() < 2) && !flush;
      pp  = (exp_q.size() != 0) && out_ready && !flush;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pp) void'(exp_q.pop_front());
        if (acc) begin
          e.d = model_res(in_op, in_a, in_b);
          e.t = in_tag;
          e.f = {e.d[63], (e.d == 64'd0)};
          exp_q.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      if (exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q[0].d);
        chk("out_tag", {58'd0, out_tag}, {58'd0, exp_q[0].t});
`ifdef LOGIC_EXEC_FLAGS_EN
        chk("out_flags", {62'd0, out_flags}, {62'd0, exp_q[0].f});
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 64'd0, 6'd0);
    #3;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_data", out_data, 64'd0);
    chk("reset out_tag", {58'd0, out_tag}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // NOR right after reset release
    out_ready = 1'b1;
    drive(1'b1, 3'd3, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 6'd5);
    step();
    in_valid = 1'b0;
    chk("nor valid", {63'd0, out_valid}, 64'd1);
    chk("nor data", out_data, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("nor tag", {58'd0, out_tag}, 64'd5);
`ifdef LOGIC_EXEC_FLAGS_EN
    chk("nor flags", {62'd0, out_flags}, 64'd2);
`endif
    step();

    // Full op sweep at one op per cycle
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, op[2:0], 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00, op[5:0] + 6'd16);
      step();
      if (op == 3) chk("sweep nor", out_data, 64'h0000_00FF_0000_00FF);
      if (op == 6) chk("sweep bic", out_data, 64'h00FF_0000_00FF_0000);
    end
    in_valid = 1'b0;
    step();

    // Backpressure: tags 1,2 fill the queue, tag 3 waits
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 64'd1, 64'd0, 6'd1);
    step();
    drive(1'b1, 3'd1, 64'd2, 64'd0, 6'd2);
    step();
    chk("bp in_ready low", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 3'd1, 64'd3, 64'd0, 6'd3);
    step();
    chk("bp head tag1", {58'd0, out_tag}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp head tag2", {58'd0, out_tag}, 64'd2);
    chk("bp in_ready back", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp head tag3", {58'd0, out_tag}, 64'd3);
    step();

    // Zero result
    drive(1'b1, 3'd0, 64'd0, 64'd0, 6'd12);
    step();
    in_valid = 1'b0;
    chk("zero data", out_data, 64'd0);
`ifdef LOGIC_EXEC_FLAGS_EN
    chk("zero flags", {62'd0, out_flags}, 64'd1);
`endif
    step();

    // Flush with two entries queued and a micro-op offered
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 64'hF0, 64'h0F, 6'd10);
    step();
    drive(1'b1, 3'd2, 64'hF1, 64'h0F, 6'd11);
    step();
    drive(1'b1, 3'd2, 64'hF2, 64'h0F, 6'd12);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset with one entry queued
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 64'h1234, 64'd0, 6'd7);
    step();
    in_valid = 1'b0;
    chk("pre-reset valid", {63'd0, out_valid}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset out_valid", {63'd0, out_valid}, 64'd0);
    chk("areset out_data", out_data, 64'd0);
    chk("areset out_tag", {58'd0, out_tag}, 64'd0);
    chk("areset in_ready", {63'd0, in_ready}, 64'd1);
    step();
    reset_n = 1'b1;
    drive(1'b1, 3'd2, 64'h3C, 64'h0F, 6'd9);
    step();
    in_valid = 1'b0;
    chk("post-reset tag", {58'd0, out_tag}, 64'd9);
    chk("post-reset data", out_data, 64'h33);
    out_ready = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
